rgb2ycbcr_arb: RTL and testbench

Frame-boundary arbiter that shares the single three-stage RGB→YCbCr converter between two streaming RGB888 video sources. It selects one source per frame, forwards that source's vsync/clken/valid/data to the converter with one register stage, and drops the other source's pixels. It also counts pixels, flags short frames and tags converter output with the source ID. It sits between the two camera/test-pattern front-ends and the converter.

---
 rtl/rgb2ycbcr_pkg.sv | 20 ++
 rtl/vsync_edge.sv | 26 ++
 rtl/rgb2ycbcr_arb.sv | 188 ++++++++++++++++++
 tb/tb_rgb2ycbcr_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2ycbcr_pkg.sv
// Shared definitions for the RGB->YCbCr front-end: arbiter FSM states,
// cfg_mode encodings and the converter latency shared with the converter.
package rgb2ycbcr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      ACTIVE,
      DRAIN
   } arb_state_e;

   localparam logic [1:0] MODE_SRC0  = 2'd0;  // source 0 only
   localparam logic [1:0] MODE_SRC1  = 2'd1;  // source 1 only
   localparam logic [1:0] MODE_RR    = 2'd2;  // alternate per frame
   localparam logic [1:0] MODE_FIRST = 2'd3;  // first vsync rise wins

   // Pipeline depth of the RGB->YCbCr converter in clk cycles.
   localparam int unsigned LAT_DEFAULT = 3;

endpackage

// File: rtl/vsync_edge.sv
// Registered rising-edge detector for a source vsync.
// Ports:
//   clk   - pixel clock
//   rst_n - asynchronous active-low reset
//   vsync - raw vsync from the source
//   rise  - high in the cycle where vsync is high and was low the cycle before
module vsync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   output logic rise
);

   logic vsync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
      end else begin
         vsync_q <= vsync;
      end
   end

   assign rise = vsync & ~vsync_q;

endmodule

// File: rtl/rgb2ycbcr_arb.sv
// Frame-boundary arbiter sharing one RGB->YCbCr converter between two RGB888
// sources. One source is granted per frame; its vsync/clken/valid/data are
// forwarded through one register stage, the other source is dropped.
// Ports:
//   clk, rst_n                     - pixel clock, async active-low reset
//   s0_*, s1_*                     - source vsync/clken/valid/data {R,G,B}
//   cfg_enable, cfg_mode           - arbitration enable and grant policy
//   rgb_vsync/clken/valid/data     - registered stream to the converter
//   out_src                        - granted source aligned with converter output
//   grant                          - currently granted source
//   busy                           - FSM outside IDLE
//   frame_done                     - pulse once a frame has left the converter
//   pix_err                        - pulse on a short frame
module rgb2ycbcr_arb
   import rgb2ycbcr_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned LAT   = LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s0_vsync,
   input  logic        s0_clken,
   input  logic        s0_valid,
   input  logic [23:0] s0_data,
   input  logic        s1_vsync,
   input  logic        s1_clken,
   input  logic        s1_valid,
   input  logic [23:0] s1_data,
   input  logic        cfg_enable,
   input  logic [1:0]  cfg_mode,
   output logic        rgb_vsync,
   output logic        rgb_clken,
   output logic        rgb_valid,
   output logic [23:0] rgb_data,
   output logic        out_src,
   output logic        grant,
   output logic        busy,
   output logic        frame_done,
   output logic        pix_err
);

   localparam int unsigned NPIX = IMG_W * IMG_H;
   localparam int unsigned CW   = $clog2(NPIX);
   localparam int unsigned DW   = $clog2(LAT + 1);

   arb_state_e    state_q, state_d;
   logic [1:0]    mode_q;
   logic          grant_q, last_grant_q, grant_tgt;
   logic [CW-1:0] pix_cnt_q;
   logic [DW-1:0] drain_cnt_q;
   logic          rise0, rise1;
   logic          sel, g_rise, pix_in, sof, last_pix, early, drain_end;
   logic          fwd, enter_wait;
   logic          vsync_q, clken_q, valid_q;
   logic [23:0]   data_q;
   logic          fwd_src_q;
   logic [LAT-1:0] src_pipe_q;
   logic          pix_err_q, frame_done_q;

   vsync_edge u_edge0 (
      .clk   (clk),
      .rst_n (rst_n),
      .vsync (s0_vsync),
      .rise  (rise0)
   );

   vsync_edge u_edge1 (
      .clk   (clk),
      .rst_n (rst_n),
      .vsync (s1_vsync),
      .rise  (rise1)
   );

   // Source selection and frame events. In first-vsync-wins mode the grant is
   // decided combinationally in the SOF cycle so that cycle can be forwarded;
   // src0 wins a same-cycle tie.
   always_comb begin
      sel = grant_q;
      if (state_q == WAIT_SOF && mode_q == MODE_FIRST) begin
         sel = ~rise0;
      end
      g_rise    = sel ? rise1 : rise0;
      pix_in    = sel ? (s1_valid & s1_clken) : (s0_valid & s0_clken);
      sof       = (state_q == WAIT_SOF) && g_rise;
      last_pix  = (state_q == ACTIVE) && pix_in && (pix_cnt_q == CW'(NPIX - 1));
      // Completion in the same cycle as an early rise takes priority.
      early     = (state_q == ACTIVE) && g_rise && !last_pix;
      drain_end = (state_q == DRAIN) && (drain_cnt_q == DW'(LAT));
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (cfg_enable) state_d = WAIT_SOF;
         WAIT_SOF: if (sof) state_d = ACTIVE;
         ACTIVE:   if (last_pix || early) state_d = DRAIN;
         DRAIN:    if (drain_end) state_d = cfg_enable ? WAIT_SOF : IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      fwd        = sof || (state_q == ACTIVE && !early);
      busy       = (state_q != IDLE);
      enter_wait = (state_d == WAIT_SOF) && (state_q != WAIT_SOF);
      // Leaving DRAIN, last_grant is updated on the same edge, so use grant_q.
      case (cfg_mode)
         MODE_SRC0: grant_tgt = 1'b0;
         MODE_SRC1: grant_tgt = 1'b1;
         MODE_RR:   grant_tgt = (state_q == DRAIN) ? ~grant_q : ~last_grant_q;
         default:   grant_tgt = grant_q;
      endcase
   end

   // Grant, counters and pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q       <= MODE_SRC0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         pix_cnt_q    <= '0;
         drain_cnt_q  <= '0;
         pix_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (enter_wait) begin
            mode_q  <= cfg_mode;
            grant_q <= grant_tgt;
         end else if (sof) begin
            grant_q <= sel;
         end
         if (drain_end) last_grant_q <= grant_q;
         if (sof) begin
            pix_cnt_q <= '0;
         end else if (state_q == ACTIVE && pix_in) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
         end
         drain_cnt_q  <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
         pix_err_q    <= early;
         frame_done_q <= drain_end;
      end
   end

   // Forward stage and source tag pipeline matching the converter latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q    <= 1'b0;
         clken_q    <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         fwd_src_q  <= 1'b0;
         src_pipe_q <= '0;
      end else begin
         vsync_q    <= fwd & (sel ? s1_vsync : s0_vsync);
         clken_q    <= fwd & (sel ? s1_clken : s0_clken);
         valid_q    <= fwd & (sel ? s1_valid : s0_valid);
         data_q     <= fwd ? (sel ? s1_data : s0_data) : '0;
         fwd_src_q  <= fwd & sel;
         src_pipe_q[0] <= fwd_src_q;
         for (int i = 1; i < LAT; i++) begin
            src_pipe_q[i] <= src_pipe_q[i-1];
         end
      end
   end

   assign rgb_vsync  = vsync_q;
   assign rgb_clken  = clken_q;
   assign rgb_valid  = valid_q;
   assign rgb_data   = data_q;
   assign out_src    = src_pipe_q[LAT-1];
   assign grant      = grant_q;
   assign frame_done = frame_done_q;
   assign pix_err    = pix_err_q;

endmodule

// File: tb/tb_rgb2ycbcr_arb.sv
// Directed bench for rgb2ycbcr_arb with a 4x2 frame and converter latency 3.
// Source 0 pixels carry {A0,5A,idx}, source 1 pixels {B1,C3,idx}, so the
// forwarded source and pixel order can be recognised on rgb_data.
module tb_rgb2ycbcr_arb;

   logic        clk, rst_n;
   logic        s0_vsync, s0_clken, s0_valid;
   logic [23:0] s0_data;
   logic        s1_vsync, s1_clken, s1_valid;
   logic [23:0] s1_data;
   logic        cfg_enable;
   logic [1:0]  cfg_mode;
   logic        rgb_vsync, rgb_clken, rgb_valid;
   logic [23:0] rgb_data;
   logic        out_src, grant, busy, frame_done, pix_err;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic        exp_grant;
   logic        dsrc;
   logic [23:0] exp_data;
   logic [2:0]  dv, ds;
   int mon_pix, mon_bad, mon_src_bad, mon_fd, mon_fd_gap, mon_pe, mon_pe_cyc, mon_vs;
   int mon_last_pix_cyc, vs_cyc, rr_fd;

   rgb2ycbcr_arb #(
      .IMG_W (4),
      .IMG_H (2),
      .LAT   (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s0_vsync   (s0_vsync),
      .s0_clken   (s0_clken),
      .s0_valid   (s0_valid),
      .s0_data    (s0_data),
      .s1_vsync   (s1_vsync),
      .s1_clken   (s1_clken),
      .s1_valid   (s1_valid),
      .s1_data    (s1_data),
      .cfg_enable (cfg_enable),
      .cfg_mode   (cfg_mode),
      .rgb_vsync  (rgb_vsync),
      .rgb_clken  (rgb_clken),
      .rgb_valid  (rgb_valid),
      .rgb_data   (rgb_data),
      .out_src    (out_src),
      .grant      (grant),
      .busy       (busy),
      .frame_done (frame_done),
      .pix_err    (pix_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         dv = '0;
         ds = '0;
      end else begin
         dsrc = (rgb_data[23:16] == 8'hB1);
         if (rgb_valid && rgb_clken) begin
            exp_data = exp_grant ? {8'hB1, 8'hC3, 8'(mon_pix)} : {8'hA0, 8'h5A, 8'(mon_pix)};
            if (rgb_data != exp_data) mon_bad++;
            mon_pix++;
            mon_last_pix_cyc = cyc;
         end else if (rgb_data != 24'h0) begin
            mon_bad++;
         end
         if (dv[2] && (out_src != ds[2])) mon_src_bad++;
         dv = {dv[1:0], rgb_valid & rgb_clken};
         ds = {ds[1:0], dsrc};
         if (rgb_vsync) mon_vs++;
         if (frame_done) begin
            mon_fd++;
            mon_fd_gap = cyc - mon_last_pix_cyc;
         end
         if (pix_err) begin
            mon_pe++;
            mon_pe_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic clr_src();
      s0_vsync = 1'b0; s0_clken = 1'b0; s0_valid = 1'b0; s0_data = '0;
      s1_vsync = 1'b0; s1_clken = 1'b0; s1_valid = 1'b0; s1_data = '0;
   endtask

   task automatic clear_mon();
      mon_pix = 0; mon_bad = 0; mon_src_bad = 0; mon_fd = 0; mon_fd_gap = -1;
      mon_pe = 0; mon_pe_cyc = -1; mon_vs = 0; mon_last_pix_cyc = 0;
   endtask

   // One-cycle vsync pulse on the selected sources, then a blank cycle.
   task automatic vs(input logic v0, input logic v1);
      clr_src();
      s0_vsync = v0;
      s1_vsync = v1;
      vs_cyc   = cyc;
      tick();
      clr_src();
      tick();
   endtask

   // n valid pixels on both sources; cfg_enable drops with pixel drop_at.
   task automatic pix(input int n, input int drop_at);
      for (int i = 0; i < n; i++) begin
         s0_valid = 1'b1; s0_clken = 1'b1; s0_data = {8'hA0, 8'h5A, 8'(i)};
         s1_valid = 1'b1; s1_clken = 1'b1; s1_data = {8'hB1, 8'hC3, 8'(i)};
         if (i == drop_at) cfg_enable = 1'b0;
         tick();
      end
      clr_src();
      tick();
   endtask

   task automatic do_reset(input logic [1:0] mode);
      rst_n = 1'b0;
      clr_src();
      cfg_enable = 1'b0;
      cfg_mode   = mode;
      idle(2);
      rst_n      = 1'b1;
      cfg_enable = 1'b1;
      idle(2);
      clear_mon();
   endtask

   initial begin
      rst_n = 1'b0;
      clr_src();
      cfg_enable = 1'b0;
      cfg_mode   = 2'd0;
      exp_grant  = 1'b0;
      clear_mon();
      idle(2);

      // Reset state.
      chk("rst_vsync", 32'(rgb_vsync), 0);
      chk("rst_clken", 32'(rgb_clken), 0);
      chk("rst_valid", 32'(rgb_valid), 0);
      chk("rst_data", 32'(rgb_data), 0);
      chk("rst_out_src", 32'(out_src), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_pix_err", 32'(pix_err), 0);

      // Mode 0, both sources streaming.
      do_reset(2'd0);
      exp_grant = 1'b0;
      chk("m0_busy_wait", 32'(busy), 1);
      vs(1'b1, 1'b1);
      pix(8, -1);
      idle(8);
      chk("m0_pix", mon_pix, 8);
      chk("m0_data", mon_bad, 0);
      chk("m0_out_src", mon_src_bad, 0);
      chk("m0_fd", mon_fd, 1);
      chk("m0_fd_gap", mon_fd_gap, 4);
      chk("m0_pix_err", mon_pe, 0);
      chk("m0_vsync_fwd", mon_vs, 1);

      // Round-robin over three frames: grants 0,1,0.
      do_reset(2'd2);
      rr_fd = 0;
      for (int f = 0; f < 3; f++) begin
         exp_grant = 1'(f % 2);
         clear_mon();
         vs(1'b1, 1'b1);
         chk($sformatf("rr%0d_grant", f), 32'(grant), 32'(f % 2));
         pix(8, -1);
         idle(8);
         chk($sformatf("rr%0d_pix", f), mon_pix, 8);
         chk($sformatf("rr%0d_data", f), mon_bad, 0);
         chk($sformatf("rr%0d_out_src", f), mon_src_bad, 0);
         rr_fd += mon_fd;
      end
      chk("rr_fd_total", rr_fd, 3);

      // First vsync wins: s1 rises two cycles before s0.
      do_reset(2'd3);
      exp_grant = 1'b1;
      clr_src();
      s1_vsync = 1'b1;
      tick();
      s1_vsync = 1'b0;
      tick();
      s0_vsync = 1'b1;
      tick();
      s0_vsync = 1'b0;
      tick();
      chk("first_s1_grant", 32'(grant), 1);
      pix(8, -1);
      idle(8);
      chk("first_s1_pix", mon_pix, 8);
      chk("first_s1_data", mon_bad, 0);
      chk("first_s1_out_src", mon_src_bad, 0);
      // Same-cycle rises: src0 wins.
      exp_grant = 1'b0;
      clear_mon();
      vs(1'b1, 1'b1);
      chk("first_tie_grant", 32'(grant), 0);
      pix(8, -1);
      idle(8);
      chk("first_tie_pix", mon_pix, 8);
      chk("first_tie_data", mon_bad, 0);

      // Short frame: granted vsync re-rises after 5 pixels.
      do_reset(2'd0);
      exp_grant = 1'b0;
      vs(1'b1, 1'b1);
      pix(5, -1);
      vs(1'b1, 1'b0);
      idle(8);
      chk("short_pix_err", mon_pe, 1);
      chk("short_pe_timing", mon_pe_cyc - vs_cyc, 1);
      chk("short_pix", mon_pix, 5);
      chk("short_vsync_fwd", mon_vs, 1);
      chk("short_data", mon_bad, 0);
      chk("short_fd", mon_fd, 1);

      // cfg_enable dropped at pixel 3: frame completes, then IDLE.
      do_reset(2'd0);
      exp_grant = 1'b0;
      vs(1'b1, 1'b1);
      pix(8, 3);
      idle(8);
      chk("dis_pix", mon_pix, 8);
      chk("dis_fd", mon_fd, 1);
      chk("dis_busy", 32'(busy), 0);
      vs(1'b1, 1'b1);
      pix(8, -1);
      idle(4);
      chk("dis_no_restart", mon_pix, 8);

      // Reset mid-frame after one completed src0 frame in round-robin.
      do_reset(2'd2);
      exp_grant = 1'b0;
      vs(1'b1, 1'b1);
      pix(8, -1);
      idle(8);
      chk("mid_f0_pix", mon_pix, 8);
      exp_grant = 1'b1;
      clear_mon();
      vs(1'b1, 1'b1);
      s0_valid = 1'b1; s0_clken = 1'b1; s0_data = {8'hA0, 8'h5A, 8'h00};
      s1_valid = 1'b1; s1_clken = 1'b1; s1_data = {8'hB1, 8'hC3, 8'h00};
      tick();
      s0_data = {8'hA0, 8'h5A, 8'h01};
      s1_data = {8'hB1, 8'hC3, 8'h01};
      tick();
      chk("mid_pre_valid", 32'(rgb_valid), 1);
      chk("mid_pre_grant", 32'(grant), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rgb_valid), 0);
      chk("mid_rst_clken", 32'(rgb_clken), 0);
      chk("mid_rst_data", 32'(rgb_data), 0);
      chk("mid_rst_grant", 32'(grant), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_out_src", 32'(out_src), 0);
      clr_src();
      idle(2);
      rst_n = 1'b1;
      idle(2);
      exp_grant = 1'b0;
      clear_mon();
      vs(1'b1, 1'b1);
      chk("mid_after_grant", 32'(grant), 0);
      pix(8, -1);
      idle(8);
      chk("mid_after_pix", mon_pix, 8);
      chk("mid_after_data", mon_bad, 0);
      chk("mid_after_fd", mon_fd, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
